// File: rtl/lif_norm_pkg.sv
// Shared definitions for the LIF normaliser datapath.
//   NORM_UNSIGNED / NORM_SIGNED : values carried on the mode bit.
//   kw_of(width)                : shift-count width for a given data width.
package lif_norm_pkg;

  localparam logic NORM_UNSIGNED = 1'b0;
  localparam logic NORM_SIGNED   = 1'b1;

  // Shift counts run 0..width-1, so ceil(log2(width)) bits are enough.
  function automatic int kw_of(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/lz_count.sv
// Combinational priority encoder producing the normalising shift count.
//   i_data : word to examine
//   i_mode : NORM_UNSIGNED -> leading-zero count
//            NORM_SIGNED   -> redundant sign-bit count
//   o_k    : shift count (0 for an all-zero word)
//   o_zero : word is all zeros
module lz_count
  import lif_norm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = kw_of(WIDTH)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_mode,
  output logic [KW-1:0]    o_k,
  output logic             o_zero
);

  logic w_found;

  always_comb begin
    o_k     = '0;
    w_found = 1'b0;
    o_zero  = (i_data == '0);
    if (i_mode == NORM_SIGNED) begin
      // First bit below the sign that differs from it marks the end of the
      // redundant sign run; the sign bit itself is never shifted out.
      for (int i = WIDTH - 2; i >= 0; i--) begin
        if (!w_found && (i_data[i] != i_data[WIDTH-1])) begin
          o_k     = KW'(WIDTH - 2 - i);
          w_found = 1'b1;
        end
      end
      // All-ones: every bit matches the sign, shift as far as possible.
      if (!w_found && !o_zero) begin
        o_k = KW'(WIDTH - 1);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (!w_found && i_data[i]) begin
          o_k     = KW'(WIDTH - 1 - i);
          w_found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/lz_norm_pipe.sv
// Two-stage pipelined leading-bit normaliser with valid/ready flow control.
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid/in_ready   : input handshake
//   in_data, in_mode    : word to normalise and its mode (0 unsigned, 1 signed)
//   out_valid/out_ready : output handshake
//   out_data            : left-normalised word
//   out_k               : shift count applied
//   out_zero            : input word was all zeros
//   out_mode            : mode carried with the result
module lz_norm_pipe
  import lif_norm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int KW    = kw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [KW-1:0]    out_k,
  output logic             out_zero,
  output logic             out_mode
);

  logic [KW-1:0]    w_k_p0;
  logic             w_zero_p0;
  logic             w_load_p1;
  logic             w_load_p2;
  logic             w_adv_p1;
  logic [WIDTH-1:0] w_shift_p1;

  logic             r_vld_p1;
  logic [WIDTH-1:0] r_data_p1;
  logic [KW-1:0]    r_k_p1;
  logic             r_zero_p1;
  logic             r_mode_p1;

  logic             r_vld_p2;
  logic [WIDTH-1:0] r_data_p2;
  logic [KW-1:0]    r_k_p2;
  logic             r_zero_p2;
  logic             r_mode_p2;

  lz_count #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_lz_count (
    .i_data (in_data),
    .i_mode (in_mode),
    .o_k    (w_k_p0),
    .o_zero (w_zero_p0)
  );

  // Stage 2 can take a word when empty or when its word leaves this cycle;
  // stage 1 drains only into a loadable stage 2. No skid buffer, so in_ready
  // is combinational from out_ready.
  assign w_load_p2 = !r_vld_p2 || out_ready;
  assign w_adv_p1  = r_vld_p1 && w_load_p2;
  assign in_ready  = !r_vld_p1 || w_adv_p1;
  assign w_load_p1 = in_valid && in_ready;

  // ---- stage 1: input word, mode, shift count, zero flag ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (in_ready) begin
      r_vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (w_load_p1) begin
      r_data_p1 <= in_data;
      r_k_p1    <= w_k_p0;
      r_zero_p1 <= w_zero_p0;
      r_mode_p1 <= in_mode;
    end
  end

  assign w_shift_p1 = r_data_p1 << r_k_p1;

  // ---- stage 2: shifted word, shift count, zero flag, mode ----
  // Payload is cleared on reset so the outputs read zero while idle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_k_p2    <= '0;
      r_zero_p2 <= 1'b0;
      r_mode_p2 <= 1'b0;
    end else if (w_load_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_data_p2 <= w_shift_p1;
        r_k_p2    <= r_k_p1;
        r_zero_p2 <= r_zero_p1;
        r_mode_p2 <= r_mode_p1;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_k     = r_k_p2;
  assign out_zero  = r_zero_p2;
  assign out_mode  = r_mode_p2;

endmodule

// File: tb/tb_lz_norm_pipe.sv
module tb_lz_norm_pipe;

  localparam int W = 8;

  typedef struct packed {
    logic         m;
    logic         z;
    logic [2:0]   k;
    logic [W-1:0] d;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   out_k;
  logic         out_zero;
  logic         out_mode;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_emit = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  lz_norm_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_k     (out_k),
    .out_zero  (out_zero),
    .out_mode  (out_mode)
  );

  // Reference: the largest left shift that loses no information.
  // Unsigned: no set bit falls off the top. Signed: the value is still
  // exactly the original times 2^k when read as two's complement.
  function automatic res_t model(input logic [W-1:0] d, input logic m);
    res_t r;
    logic [W-1:0] s;
    int kk;
    kk = 0;
    for (int k = 0; k < W; k++) begin
      s = d << k;
      if (d != 0) begin
        if (m == 1'b0) begin
          if ((s >> k) == d) kk = k;
        end else begin
          if (int'($signed(s)) == int'($signed(d)) * (1 << k)) kk = k;
        end
      end
    end
    r.m = m;
    r.z = (d == 0);
    r.k = 3'(kk);
    r.d = d << kk;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every valid output cycle is checked against the oldest
  // accepted word; handshake flags read at negedge hold through the next edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_output", 1, 0);
        end else begin
          chk("sb_result", int'({out_mode, out_zero, out_k, out_data}), int'(sb[0]));
          if (out_ready) begin
            void'(sb.pop_front());
            n_emit++;
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_data, in_mode));
    end
  end

  // Drive a word starting just after a rising edge; return just after the
  // edge that accepted it.
  task automatic send(input logic [W-1:0] d, input logic m);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // One word through an empty pipe with out_ready high: not visible before the
  // second edge, then visible with the hand-computed result.
  task automatic single(input logic [W-1:0] d, input logic m,
                        input int ek, input int ed, input int ez, input string name);
    send(d, m);
    @(negedge clk);
    chk({name, "_early"}, int'(out_valid), 0);
    @(negedge clk);
    chk({name, "_valid"}, int'(out_valid), 1);
    chk({name, "_res"}, int'({out_mode, out_zero, out_k, out_data}),
        int'({m, 1'(ez), 3'(ek), 8'(ed)}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  logic [W-1:0] burst[5] = '{8'h13, 8'hF3, 8'h05, 8'h01, 8'h80};
  logic [W-1:0] bp[3]    = '{8'h2A, 8'hC7, 8'h03};
  res_t  tmp;
  logic  rdy;
  int    idx;
  int    base;
  logic [15:0] snap;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;

    // Model pins against hand-derived values.
    tmp = model(8'h13, 1'b0); chk("model_u13", int'({tmp.k, tmp.d}), int'({3'd3, 8'h98}));
    tmp = model(8'h01, 1'b0); chk("model_u01", int'({tmp.k, tmp.d}), int'({3'd7, 8'h80}));
    tmp = model(8'hF3, 1'b1); chk("model_sF3", int'({tmp.k, tmp.d}), int'({3'd3, 8'h98}));
    tmp = model(8'h05, 1'b1); chk("model_s05", int'({tmp.k, tmp.d}), int'({3'd4, 8'h50}));
    tmp = model(8'hFF, 1'b1); chk("model_sFF", int'({tmp.k, tmp.d}), int'({3'd7, 8'h80}));
    tmp = model(8'h00, 1'b1); chk("model_s00", int'({tmp.z, tmp.k, tmp.d}), int'({1'b1, 3'd0, 8'h00}));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", int'({out_valid, out_data, out_k, out_zero, out_mode}), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    single(8'h13, 1'b0, 3, 8'h98, 0, "u13");
    single(8'h01, 1'b0, 7, 8'h80, 0, "u01");
    single(8'hF3, 1'b1, 3, 8'h98, 0, "sF3");
    single(8'h05, 1'b1, 4, 8'h50, 0, "s05");
    single(8'hFF, 1'b1, 7, 8'h80, 0, "sFF");
    single(8'h40, 1'b1, 0, 8'h40, 0, "s40");
    single(8'h00, 1'b0, 0, 8'h00, 1, "u00");
    single(8'h00, 1'b1, 0, 8'h00, 1, "s00");
    single(8'h80, 1'b0, 0, 8'h80, 0, "u80");

    // Back-to-back burst of 5: results on 5 consecutive cycles.
    for (int c = 0; c < 8; c++) begin
      if (c < 5) begin
        in_valid = 1'b1;
        in_data  = burst[c];
        in_mode  = 1'(c & 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (c < 5) chk("burst_in_ready", int'(in_ready), 1);
      chk("burst_out_valid", int'(out_valid), (c >= 2 && c <= 6) ? 1 : 0);
      @(posedge clk);
      #1;
    end

    // Backpressure: 3 words offered over 4 stalled cycles.
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin
        in_data = bp[idx];
        in_mode = 1'b1;
      end
      @(negedge clk);
      rdy = in_ready;
      if (c == 2) snap = {out_valid, out_mode, out_zero, out_k, out_data};
      if (c == 3) chk("bp_stable", int'({out_valid, out_mode, out_zero, out_k, out_data}), int'(snap));
      @(posedge clk);
      #1;
      if (rdy && in_valid) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready_low", int'(in_ready), 0);
    base = n_emit;
    out_ready = 1'b1;
    send(bp[2], 1'b1);
    for (int t = 0; t < 20 && (sb.size() != 0 || out_valid); t++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_emitted", n_emit - base, 3);
    chk("bp_drained", sb.size(), 0);

    // Async reset with two words in flight.
    out_ready = 1'b0;
    send(8'h21, 1'b0);
    send(8'h0C, 1'b1);
    chk("rst_inflight", int'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_clear", int'({out_valid, out_data, out_k, out_zero, out_mode}), 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_no_stale", int'(out_valid), 0);
    @(posedge clk);
    #1;
    single(8'h30, 1'b0, 2, 8'hC0, 0, "post_rst");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
